// File: rtl/biu_mem_arb_if.sv
// ============================================================================
// Module      : biu_mem_arb_if
// Description : Bundle of the two requester ports and the shared memory port
//               of the BIU memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface biu_mem_arb_if;

    // Requester 0
    logic        m0_req;
    logic        m0_lock;
    logic [31:0] m0_addr;
    logic [31:0] m0_wr_dat;
    logic [3:0]  m0_wr_ena;
    logic [3:0]  m0_rd_ena;
    logic        m0_gnt;
    logic        m0_rvalid;

    // Requester 1
    logic        m1_req;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic [31:0] m1_wr_dat;
    logic [3:0]  m1_wr_ena;
    logic [3:0]  m1_rd_ena;
    logic        m1_gnt;
    logic        m1_rvalid;

    // Memory side and shared read return
    logic [31:0] rd_dat_o;
    logic [31:0] addr_o;
    logic [31:0] wr_dat_o;
    logic [3:0]  wr_ena_o;
    logic [3:0]  rd_ena_o;
    logic [31:0] rd_dat_i;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_wr_dat, m0_wr_ena, m0_rd_ena,
        input  m1_req, m1_lock, m1_addr, m1_wr_dat, m1_wr_ena, m1_rd_ena,
        input  rd_dat_i,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        output rd_dat_o, addr_o, wr_dat_o, wr_ena_o, rd_ena_o
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_wr_dat, m0_wr_ena, m0_rd_ena,
        output m1_req, m1_lock, m1_addr, m1_wr_dat, m1_wr_ena, m1_rd_ena,
        output rd_dat_i,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        input  rd_dat_o, addr_o, wr_dat_o, wr_ena_o, rd_ena_o
    );

endinterface

`default_nettype wire

// File: rtl/biu_mem_arb.sv
// ============================================================================
// Module      : biu_mem_arb
// Description : Two-requester single-beat memory arbiter with round-robin tie
//               break, bounded ownership locking and tagged read return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module biu_mem_arb #(
    parameter int LOCK_MAX = 16
) (
    input  logic          hclk,
    input  logic          hrstn,
    biu_mem_arb_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    localparam logic [7:0] c_CNT_MAX = 8'(LOCK_MAX - 1);

    logic [1:0]  r_state;
    logic        r_ptr;
    logic [7:0]  r_cnt;
    logic        r_rvalid0;
    logic        r_rvalid1;

    logic [1:0]  w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_cnt_inc;
    logic        w_cnt_full;
    logic        w_vld0;
    logic        w_vld1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic [31:0] w_addr;
    logic [31:0] w_wdat;
    logic [3:0]  w_wena;
    logic [3:0]  w_rena_raw;
    logic [3:0]  w_rena;

    // A request with no byte lanes enabled carries no work and is ignored.
    assign w_vld0 = bus.m0_req && ((bus.m0_wr_ena | bus.m0_rd_ena) != 4'h0);
    assign w_vld1 = bus.m1_req && ((bus.m1_wr_ena | bus.m1_rd_ena) != 4'h0);

    assign w_cnt_inc  = (r_cnt >= c_CNT_MAX) ? c_CNT_MAX : r_cnt + 8'd1;
    assign w_cnt_full = (w_cnt_inc == c_CNT_MAX);

    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_gnt0) begin
                r_ptr <= 1'b0;
            end else if (w_gnt1) begin
                r_ptr <= 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 8'd0;
                // Pointer holds the last owner, so a tie goes to the other one.
                if (w_vld0 && w_vld1) begin
                    w_gnt0 = r_ptr;
                    w_gnt1 = ~r_ptr;
                end else begin
                    w_gnt0 = w_vld0;
                    w_gnt1 = w_vld1;
                end
                if (w_gnt0 && bus.m0_lock) begin
                    w_state_nxt = S_OWN0;
                end else if (w_gnt1 && bus.m1_lock) begin
                    w_state_nxt = S_OWN1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OWN0: begin
                w_gnt0 = w_vld0;
                if (w_vld0) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                if (w_vld0 && bus.m0_lock && !(w_cnt_full && w_vld1)) begin
                    w_state_nxt = S_OWN0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OWN1: begin
                w_gnt1 = w_vld1;
                if (w_vld1) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                if (w_vld1 && bus.m1_lock && !(w_cnt_full && w_vld0)) begin
                    w_state_nxt = S_OWN1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (!hrstn) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_comb begin
        w_addr     = 32'h0;
        w_wdat     = 32'h0;
        w_wena     = 4'h0;
        w_rena_raw = 4'h0;
        if (w_gnt0) begin
            w_addr     = bus.m0_addr;
            w_wdat     = bus.m0_wr_dat;
            w_wena     = bus.m0_wr_ena;
            w_rena_raw = bus.m0_rd_ena;
        end else if (w_gnt1) begin
            w_addr     = bus.m1_addr;
            w_wdat     = bus.m1_wr_dat;
            w_wena     = bus.m1_wr_ena;
            w_rena_raw = bus.m1_rd_ena;
        end
        // A mixed beat is treated as a pure write.
        w_rena = (w_wena != 4'h0) ? 4'h0 : w_rena_raw;
    end

    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 && (w_rena != 4'h0);
            r_rvalid1 <= w_gnt1 && (w_rena != 4'h0);
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = r_rvalid0;
    assign bus.m1_rvalid = r_rvalid1;
    assign bus.addr_o    = w_addr;
    assign bus.wr_dat_o  = w_wdat;
    assign bus.wr_ena_o  = w_wena;
    assign bus.rd_ena_o  = w_rena;
    assign bus.rd_dat_o  = bus.rd_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_biu_mem_arb.sv
// ============================================================================
// Module      : tb_biu_mem_arb
// Description : Directed self-checking bench for biu_mem_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_biu_mem_arb;

    logic hclk;
    logic hrstn;
    int   n_checks;
    int   n_errors;

    biu_mem_arb_if bus ();

    biu_mem_arb #(.LOCK_MAX(16)) u_dut (
        .hclk  (hclk),
        .hrstn (hrstn),
        .bus   (bus.slave)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic drive_m0(input logic req, input logic lock, input logic [31:0] addr,
                            input logic [31:0] dat, input logic [3:0] we, input logic [3:0] re);
        bus.m0_req    = req;
        bus.m0_lock   = lock;
        bus.m0_addr   = addr;
        bus.m0_wr_dat = dat;
        bus.m0_wr_ena = we;
        bus.m0_rd_ena = re;
    endtask

    task automatic drive_m1(input logic req, input logic lock, input logic [31:0] addr,
                            input logic [31:0] dat, input logic [3:0] we, input logic [3:0] re);
        bus.m1_req    = req;
        bus.m1_lock   = lock;
        bus.m1_addr   = addr;
        bus.m1_wr_dat = dat;
        bus.m1_wr_ena = we;
        bus.m1_rd_ena = re;
    endtask

    task automatic drive_idle();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        bus.rd_dat_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hrstn = 1'b0;
        drive_idle();
        repeat (2) @(negedge hclk);
        hrstn = 1'b1;
    endtask

    task automatic test_reset();
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 4'hF);
        @(negedge hclk);
        #1;
        n_checks++;
        if (bus.m0_gnt !== 1'b0) begin
            n_errors++; $display("FAIL reset_gnt: got %b want 0", bus.m0_gnt);
        end
        n_checks++;
        if (bus.rd_ena_o !== 4'h0) begin
            n_errors++; $display("FAIL reset_rd_ena: got %h want 0", bus.rd_ena_o);
        end
        n_checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) begin
            n_errors++; $display("FAIL reset_rvalid: got %b want 00", {bus.m1_rvalid, bus.m0_rvalid});
        end
        @(negedge hclk);
        hrstn = 1'b1;
        drive_idle();
    endtask

    task automatic test_single_read();
        @(negedge hclk);
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 4'hF);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
            n_errors++; $display("FAIL rd_gnt: got %b want 01", {bus.m1_gnt, bus.m0_gnt});
        end
        n_checks++;
        if (bus.addr_o !== 32'h10) begin
            n_errors++; $display("FAIL rd_addr: got %h want 10", bus.addr_o);
        end
        n_checks++;
        if (bus.rd_ena_o !== 4'hF) begin
            n_errors++; $display("FAIL rd_ena: got %h want f", bus.rd_ena_o);
        end
        @(negedge hclk);
        drive_idle();
        bus.rd_dat_i = 32'hCAFE_F00D;
        #1;
        n_checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b01) begin
            n_errors++; $display("FAIL rd_rvalid: got %b want 01", {bus.m1_rvalid, bus.m0_rvalid});
        end
        n_checks++;
        if (bus.rd_dat_o !== 32'hCAFE_F00D) begin
            n_errors++; $display("FAIL rd_data: got %h want cafef00d", bus.rd_dat_o);
        end
        @(negedge hclk);
        #1;
        n_checks++;
        if (bus.m0_rvalid !== 1'b0) begin
            n_errors++; $display("FAIL rd_rvalid_once: got %b want 0", bus.m0_rvalid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [31:0] exp_a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            drive_m0(1'b1, 1'b0, 32'h100 + 32'(i), 32'hA0, 4'hF, 4'h0);
            drive_m1(1'b1, 1'b0, 32'h200 + 32'(i), 32'hB0, 4'hF, 4'h0);
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 32'h100 + 32'(i) : 32'h200 + 32'(i);
            n_checks++;
            if ({bus.m1_gnt, bus.m0_gnt} !== exp_g) begin
                n_errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {bus.m1_gnt, bus.m0_gnt}, exp_g);
            end
            n_checks++;
            if (bus.addr_o !== exp_a) begin
                n_errors++; $display("FAIL rr_addr[%0d]: got %h want %h", i, bus.addr_o, exp_a);
            end
        end
        @(negedge hclk);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 4'h0);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt, bus.addr_o} !== 34'h0) begin
            n_errors++; $display("FAIL no_ena_req: got gnt=%b addr=%h want 00/0", {bus.m1_gnt, bus.m0_gnt}, bus.addr_o);
        end
        n_checks++;
        if ({bus.m1_rvalid, bus.m0_rvalid} !== 2'b00) begin
            n_errors++; $display("FAIL wr_no_rvalid: got %b want 00", {bus.m1_rvalid, bus.m0_rvalid});
        end
        drive_idle();
    endtask

    task automatic test_lock_limit();
        do_reset();
        @(negedge hclk);
        drive_m1(1'b1, 1'b1, 32'h400, 32'h11, 4'hF, 4'h0);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin
            n_errors++; $display("FAIL lock_beat[0]: got %b want 10", {bus.m1_gnt, bus.m0_gnt});
        end
        for (int i = 1; i < 16; i++) begin
            @(negedge hclk);
            drive_m0(1'b1, 1'b0, 32'h500, 32'h22, 4'hF, 4'h0);
            drive_m1(1'b1, 1'b1, 32'h400 + 32'(i), 32'h11, 4'hF, 4'h0);
            #1;
            n_checks++;
            if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin
                n_errors++; $display("FAIL lock_beat[%0d]: got %b want 10", i, {bus.m1_gnt, bus.m0_gnt});
            end
        end
        @(negedge hclk);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
            n_errors++; $display("FAIL lock_release: got %b want 01", {bus.m1_gnt, bus.m0_gnt});
        end
        n_checks++;
        if (bus.addr_o !== 32'h500) begin
            n_errors++; $display("FAIL lock_release_addr: got %h want 500", bus.addr_o);
        end
        drive_idle();
    endtask

    task automatic test_lock_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge hclk);
            drive_m0(1'b1, 1'b1, 32'h600 + 32'(i), 32'h33, 4'hF, 4'h0);
            #1;
            n_checks++;
            if (bus.m0_gnt !== 1'b1) begin
                n_errors++; $display("FAIL sat_beat[%0d]: got %b want 1", i, bus.m0_gnt);
            end
        end
        @(negedge hclk);
        drive_m1(1'b1, 1'b0, 32'h700, 32'h44, 4'hF, 4'h0);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
            n_errors++; $display("FAIL sat_last: got %b want 01", {bus.m1_gnt, bus.m0_gnt});
        end
        @(negedge hclk);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin
            n_errors++; $display("FAIL sat_handover: got %b want 10", {bus.m1_gnt, bus.m0_gnt});
        end
        drive_idle();
    endtask

    task automatic test_write_wins();
        do_reset();
        @(negedge hclk);
        drive_m0(1'b1, 1'b0, 32'h20, 32'h1234_5678, 4'h3, 4'hF);
        #1;
        n_checks++;
        if ({bus.wr_ena_o, bus.rd_ena_o} !== 8'h30) begin
            n_errors++; $display("FAIL ww_enables: got wr=%h rd=%h want 3/0", bus.wr_ena_o, bus.rd_ena_o);
        end
        n_checks++;
        if (bus.wr_dat_o !== 32'h1234_5678) begin
            n_errors++; $display("FAIL ww_data: got %h want 12345678", bus.wr_dat_o);
        end
        @(negedge hclk);
        drive_idle();
        #1;
        n_checks++;
        if (bus.m0_rvalid !== 1'b0) begin
            n_errors++; $display("FAIL ww_rvalid: got %b want 0", bus.m0_rvalid);
        end
    endtask

    task automatic test_lock_drop();
        do_reset();
        @(negedge hclk);
        drive_m0(1'b1, 1'b1, 32'h30, 32'h55, 4'hF, 4'h0);
        #1;
        n_checks++;
        if (bus.m0_gnt !== 1'b1) begin
            n_errors++; $display("FAIL drop_first: got %b want 1", bus.m0_gnt);
        end
        @(negedge hclk);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 32'h40, 32'h66, 4'hF, 4'h0);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt, bus.wr_ena_o} !== 6'h0) begin
            n_errors++; $display("FAIL drop_blocked: got gnt=%b wr=%h want 00/0", {bus.m1_gnt, bus.m0_gnt}, bus.wr_ena_o);
        end
        @(negedge hclk);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10 || bus.addr_o !== 32'h40) begin
            n_errors++; $display("FAIL drop_m1: got gnt=%b addr=%h want 10/40", {bus.m1_gnt, bus.m0_gnt}, bus.addr_o);
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rv;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge hclk);
            if (i < 3) begin
                drive_m0(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 4'hF);
                drive_m1(1'b1, 1'b0, 32'h60, 32'h0, 4'h0, 4'hF);
            end else begin
                drive_idle();
            end
            bus.rd_dat_i = 32'hD000_0000 + 32'(i);
            #1;
            case (i)
                1:       exp_rv = 2'b01;
                2:       exp_rv = 2'b10;
                3:       exp_rv = 2'b01;
                default: exp_rv = 2'b00;
            endcase
            n_checks++;
            if ({bus.m1_rvalid, bus.m0_rvalid} !== exp_rv) begin
                n_errors++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", i, {bus.m1_rvalid, bus.m0_rvalid}, exp_rv);
            end
            n_checks++;
            if (bus.rd_dat_o !== 32'hD000_0000 + 32'(i)) begin
                n_errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.rd_dat_o, 32'hD000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge hclk);
        drive_m1(1'b1, 1'b0, 32'h70, 32'h0, 4'h0, 4'hF);
        #1;
        n_checks++;
        if (bus.m1_gnt !== 1'b1) begin
            n_errors++; $display("FAIL mid_gnt: got %b want 1", bus.m1_gnt);
        end
        #2;
        hrstn = 1'b0;
        drive_idle();
        @(negedge hclk);
        #1;
        n_checks++;
        if (bus.m1_rvalid !== 1'b0) begin
            n_errors++; $display("FAIL mid_rvalid_rst: got %b want 0", bus.m1_rvalid);
        end
        @(negedge hclk);
        hrstn = 1'b1;
        @(negedge hclk);
        #1;
        n_checks++;
        if (bus.m1_rvalid !== 1'b0) begin
            n_errors++; $display("FAIL mid_rvalid_post: got %b want 0", bus.m1_rvalid);
        end
        @(negedge hclk);
        drive_m0(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 4'h0);
        drive_m1(1'b1, 1'b0, 32'h90, 32'h0, 4'hF, 4'h0);
        #1;
        n_checks++;
        if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01) begin
            n_errors++; $display("FAIL mid_tie: got %b want 01", {bus.m1_gnt, bus.m0_gnt});
        end
        drive_idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        hrstn    = 1'b0;
        drive_idle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_limit();
        test_lock_saturate();
        test_write_wins();
        test_lock_drop();
        test_back_to_back();
        test_reset_mid_read();
        repeat (2) @(negedge hclk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
